calc_core: RTL and testbench

- Arithmetic engine directly downstream of the calculator AXI4-Lite register slave.
- Receives two operands, an opcode and a start pulse decoded from the slave's control register.
- Returns result, upper-word/remainder and status, which the slave exposes for readback.
- Single-cycle ALU ops; iterative shift-add multiply and restoring divide, one bit per cycle.

---
 rtl/calc_core.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_calc_core.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_core.sv
// calc_core: arithmetic engine behind the calculator register slave.
// ADD/SUB/AND/OR/XOR complete in one cycle. MUL is an iterative shift-add and
// DIV a restoring divide, each producing one bit per cycle.
// An optional sticky interrupt output is compiled in when CALC_CORE_IRQ_EN is
// defined. That build adds the ports irq and irq_clr.
//
// Handshake: a request is taken on a rising edge where start=1 and the FSM is
// IDLE. busy is 1 from that edge until the completion edge. At the completion
// edge done pulses for one cycle and the outputs update. A start seen while
// busy=1 is dropped, and nothing is queued.
module calc_core #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  start,
   input  logic [2:0]            opcode,
   input  logic [DATA_WIDTH-1:0] operand_a,
   input  logic [DATA_WIDTH-1:0] operand_b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result,
   output logic [DATA_WIDTH-1:0] result_hi,
   output logic                  flag_carry,
   output logic                  flag_zero,
   output logic                  err_div0,
   output logic                  err_opcode
`ifdef CALC_CORE_IRQ_EN
   ,
   input  logic                  irq_clr,
   output logic                  irq
`endif
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd2;
   localparam logic [2:0] OP_DIV = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_OR  = 3'd5;
   localparam logic [2:0] OP_XOR = 3'd6;

   // state_q is the observable FSM state for external checkers.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ALU  = 2'd1,
      S_ITER = 2'd2,
      S_FIN  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   // Shared iteration registers.
   // MUL: hi holds the partial product and lo holds the multiplier.
   // DIV: hi holds the partial remainder, and lo holds the dividend being
   // shifted out as quotient bits are shifted in.
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;

   logic [W-1:0]     result_q, result_d;
   logic [W-1:0]     result_hi_q, result_hi_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             div0_q, div0_d;
   logic             eop_q, eop_d;
   logic             done_q, done_d;

   // Single-cycle datapath results, formed from the latched operands.
   logic [W:0]       add_sum;
   logic [W:0]       sub_diff;
   logic [W-1:0]     alu_res;
   logic [W-1:0]     alu_hi;
   logic             alu_carry;
   logic             alu_div0;
   logic             alu_eop;

   // Per-iteration datapath values.
   logic [W:0]       mul_sum;
   logic [W:0]       div_shift;
   logic [W:0]       div_diff;

   // One-cycle operations. Only a DIV with a zero divisor ever reaches S_ALU,
   // so the DIV branch is the divide-by-zero case.
   always_comb begin
      add_sum   = {1'b0, a_q} + {1'b0, b_q};
      sub_diff  = {1'b0, a_q} - {1'b0, b_q};
      alu_res   = '0;
      alu_hi    = '0;
      alu_carry = 1'b0;
      alu_div0  = 1'b0;
      alu_eop   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res   = add_sum[W-1:0];
            alu_carry = add_sum[W];
         end
         OP_SUB: begin
            alu_res   = sub_diff[W-1:0];
            alu_carry = sub_diff[W];
         end
         OP_DIV: begin
            alu_res  = '1;
            alu_hi   = a_q;
            alu_div0 = 1'b1;
         end
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_XOR:  alu_res = a_q ^ b_q;
         default: alu_eop = 1'b1;
      endcase
   end

   // One multiply or divide step on the shared hi/lo registers.
   always_comb begin
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
      div_shift = {hi_q, lo_q[W-1]};
      div_diff  = div_shift - {1'b0, b_q};
   end

   // FSM next-state logic. This block also sets the next value of the
   // operand, accumulator and output registers.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      div0_d      = div0_q;
      eop_d       = eop_q;
      done_d      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d  = opcode;
               a_d   = operand_a;
               b_d   = operand_b;
               cnt_d = '0;
               hi_d  = '0;
               lo_d  = (opcode == OP_MUL) ? operand_b : operand_a;
               if ((opcode == OP_MUL) ||
                   ((opcode == OP_DIV) && (operand_b != '0))) begin
                  state_d = S_ITER;
               end else begin
                  state_d = S_ALU;
               end
            end
         end
         S_ALU: begin
            result_d    = alu_res;
            result_hi_d = alu_hi;
            carry_d     = alu_carry;
            zero_d      = (alu_res == '0);
            div0_d      = alu_div0;
            eop_d       = alu_eop;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
         S_ITER: begin
            if (op_q == OP_MUL) begin
               // Add the multiplicand when the multiplier LSB is set, then
               // shift the {carry, hi, lo} accumulator right by one bit.
               hi_d = mul_sum[W:1];
               lo_d = {mul_sum[0], lo_q[W-1:1]};
            end else begin
               // Restoring step: keep the subtraction only when it does not
               // borrow, and shift the matching quotient bit in at the bottom.
               if (!div_diff[W]) begin
                  hi_d = div_diff[W-1:0];
                  lo_d = {lo_q[W-2:0], 1'b1};
               end else begin
                  hi_d = div_shift[W-1:0];
                  lo_d = {lo_q[W-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CNT_W'(W)) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            result_d    = lo_q;
            result_hi_d = hi_q;
            carry_d     = 1'b0;
            zero_d      = (lo_q == '0);
            div0_d      = 1'b0;
            eop_d       = 1'b0;
            done_d      = 1'b1;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FSM state register. An asynchronous reset drops any operation in flight.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers. Reset clears every visible output.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         cnt_q       <= '0;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         div0_q      <= 1'b0;
         eop_q       <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         a_q         <= a_d;
         b_q         <= b_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         div0_q      <= div0_d;
         eop_q       <= eop_d;
         done_q      <= done_d;
      end
   end

`ifdef CALC_CORE_IRQ_EN
   logic irq_q, irq_d;

   // Sticky interrupt. Every completion sets it, and irq_clr clears it.
   // A completion on the same edge as irq_clr leaves it set.
   always_comb begin
      irq_d = irq_q;
      if (done_d) begin
         irq_d = 1'b1;
      end else if (irq_clr) begin
         irq_d = 1'b0;
      end
   end

   // Interrupt register.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`endif

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign result     = result_q;
   assign result_hi  = result_hi_q;
   assign flag_carry = carry_q;
   assign flag_zero  = zero_q;
   assign err_div0   = div0_q;
   assign err_opcode = eop_q;

endmodule

// File: tb/tb_calc_core.sv
// Testbench for calc_core (DATA_WIDTH=32).
// It applies a table of directed vectors, then random operations that are
// compared with a plain-arithmetic model. Hand-written sequences cover an
// ignored start, output hold, and reset during an operation.
module tb_calc_core;

   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        start;
   logic [2:0]  opcode;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] result_hi;
   logic        flag_carry;
   logic        flag_zero;
   logic        err_div0;
   logic        err_opcode;
`ifdef CALC_CORE_IRQ_EN
   logic        irq_clr;
   logic        irq;
`endif

   int total = 0;
   int bad   = 0;

   calc_core #(.DATA_WIDTH(32)) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .start      (start),
      .opcode     (opcode),
      .operand_a  (operand_a),
      .operand_b  (operand_b),
      .busy       (busy),
      .done       (done),
      .result     (result),
      .result_hi  (result_hi),
      .flag_carry (flag_carry),
      .flag_zero  (flag_zero),
      .err_div0   (err_div0),
      .err_opcode (err_opcode)
`ifdef CALC_CORE_IRQ_EN
      ,
      .irq_clr    (irq_clr),
      .irq        (irq)
`endif
   );

   always #5 ACLK = ~ACLK;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      logic [31:0] exp_hi;
      logic        exp_c;
      logic        exp_z;
      logic        exp_d0;
      logic        exp_eo;
      int          exp_lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] res, input logic [31:0] hi, input logic c,
                               input logic z, input logic d0, input logic eo, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.exp_res = res; v.exp_hi = hi;
      v.exp_c = c; v.exp_z = z; v.exp_d0 = d0; v.exp_eo = eo; v.exp_lat = lat;
      return v;
   endfunction

   // Reference model built from the arithmetic definition of each opcode.
   function automatic vec_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      vec_t        v;
      logic [32:0] s;
      logic [63:0] p;
      v = mk(op, a, b, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      case (op)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; v.exp_res = s[31:0]; v.exp_c = s[32]; end
         3'd1: begin v.exp_res = a - b; v.exp_c = (a < b); end
         3'd2: begin
            p = {32'd0, a} * {32'd0, b};
            v.exp_res = p[31:0]; v.exp_hi = p[63:32]; v.exp_lat = 33;
         end
         3'd3: begin
            if (b == 32'd0) begin
               v.exp_res = 32'hFFFF_FFFF; v.exp_hi = a; v.exp_d0 = 1'b1;
            end else begin
               v.exp_res = a / b; v.exp_hi = a % b; v.exp_lat = 33;
            end
         end
         3'd4: v.exp_res = a & b;
         3'd5: v.exp_res = a | b;
         3'd6: v.exp_res = a ^ b;
         default: v.exp_eo = 1'b1;
      endcase
      v.exp_z = (v.exp_res == 32'd0);
      return v;
   endfunction

   // Issues one request (the task is entered just after a clock edge) and
   // checks the completion. When poke_at is nonzero, a conflicting start with
   // random inputs is pulsed poke_at cycles after acceptance.
   task automatic run_and_check(input string tag, input vec_t v, input int poke_at);
      int lat;
      bit seen;
      opcode = v.op; operand_a = v.a; operand_b = v.b; start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      operand_a = $urandom; operand_b = $urandom; opcode = 3'($urandom_range(0, 7));
      chk({tag, " busy_accept"}, {63'd0, busy}, 64'd1);
      lat = 0; seen = 1'b0;
      while (!seen && lat < 100) begin
         if (poke_at != 0 && lat == poke_at) begin
            start = 1'b1; opcode = 3'($urandom_range(0, 7));
            operand_a = $urandom; operand_b = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge ACLK); #1;
         lat++;
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      chk({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
      chk({tag, " busy_done"}, {63'd0, busy}, 64'd0);
      chk({tag, " result"}, {32'd0, result}, {32'd0, v.exp_res});
      chk({tag, " result_hi"}, {32'd0, result_hi}, {32'd0, v.exp_hi});
      chk({tag, " flags"}, {60'd0, flag_carry, flag_zero, err_div0, err_opcode},
          {60'd0, v.exp_c, v.exp_z, v.exp_d0, v.exp_eo});
   endtask

   vec_t tbl[14];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   dcnt;
      logic [31:0] ra, rb;
      logic [2:0]  rop;

      tbl[0]  = mk(3'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      tbl[1]  = mk(3'd2, 32'h0001_0000, 32'h0003_0000, 32'h0000_0000, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0, 33);
      tbl[2]  = mk(3'd3, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0, 33);
      tbl[3]  = mk(3'd3, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1);
      tbl[4]  = mk(3'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
      tbl[5]  = mk(3'd7, 32'h1234, 32'd5, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1);
      tbl[6]  = mk(3'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      tbl[7]  = mk(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1);
      tbl[8]  = mk(3'd5, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      tbl[9]  = mk(3'd1, 32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      tbl[10] = mk(3'd3, 32'd7, 32'd100, 32'd0, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 33);
      tbl[11] = mk(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0, 33);
      tbl[12] = mk(3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1);
      tbl[13] = mk(3'd3, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 33);

      // Clock and reset.
      ARESETN = 1'b0; start = 1'b0; opcode = 3'd0; operand_a = '0; operand_b = '0;
`ifdef CALC_CORE_IRQ_EN
      irq_clr = 1'b0;
`endif
      repeat (2) @(posedge ACLK);
      #1;
      chk("reset outputs", {busy, done, flag_carry, flag_zero, err_div0, err_opcode, result, result_hi[25:0]},
          64'd0);
`ifdef CALC_CORE_IRQ_EN
      chk("reset irq", {63'd0, irq}, 64'd0);
`endif
      ARESETN = 1'b1;
      @(posedge ACLK); #1;

      // Directed vectors, issued back to back.
      for (int i = 0; i < 14; i++) begin
         run_and_check($sformatf("vec%0d", i), tbl[i], 0);
      end

      // Outputs hold between done pulses while the inputs change.
      repeat (3) begin
         operand_a = $urandom; operand_b = $urandom;
         @(posedge ACLK); #1;
         chk("hold done_low", {63'd0, done}, 64'd0);
      end
      chk("hold result", {32'd0, result}, {32'd0, tbl[13].exp_res});

      // A start pulsed 10 cycles into a MUL is ignored.
      run_and_check("mul_poke", model(3'd2, 32'd12345, 32'd678), 10);
      run_and_check("div_poke", model(3'd3, 32'hDEAD_BEEF, 32'd1234), 20);

      // A start held over the completion edge is ignored.
      opcode = 3'd0; operand_a = 32'd10; operand_b = 32'd20; start = 1'b1;
      @(posedge ACLK); #1;
      opcode = 3'd1; operand_a = 32'd1; operand_b = 32'd2;
      @(posedge ACLK); #1;
      start = 1'b0;
      chk("overlap done", {63'd0, done}, 64'd1);
      chk("overlap result", {32'd0, result}, 64'd30);
      @(posedge ACLK); #1;
      chk("overlap no_restart", {62'd0, busy, done}, 64'd0);
      @(posedge ACLK); #1;
      chk("overlap hold", {31'd0, done, result}, 64'd30);

      // Random operations compared with the model.
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 300));
            default: rb = $urandom;
         endcase
         run_and_check($sformatf("rnd%0d", i), model(rop, ra, rb), 0);
      end

      // Reset during iteration 16 of a DIV.
      run_and_check("pre_reset", tbl[0], 0);
      opcode = 3'd3; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0;
      repeat (16) @(posedge ACLK);
      #1;
      ARESETN = 1'b0;
      #1;
      chk("midreset busy_done", {62'd0, busy, done}, 64'd0);
      chk("midreset result", {result, result_hi}, 64'd0);
      chk("midreset flags", {60'd0, flag_carry, flag_zero, err_div0, err_opcode}, 64'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      dcnt = 0;
      repeat (40) begin
         @(posedge ACLK); #1;
         if (done) dcnt++;
      end
      chk("midreset no_done", 64'(dcnt), 64'd0);
      run_and_check("post_reset", tbl[2], 0);

`ifdef CALC_CORE_IRQ_EN
      chk("irq set", {63'd0, irq}, 64'd1);
      irq_clr = 1'b1;
      @(posedge ACLK); #1;
      irq_clr = 1'b0;
      chk("irq cleared", {63'd0, irq}, 64'd0);
      run_and_check("irq_op", tbl[4], 0);
      chk("irq set_again", {63'd0, irq}, 64'd1);
      irq_clr = 1'b1;
      @(posedge ACLK); #1;
      irq_clr = 1'b0;
      opcode = 3'd0; operand_a = 32'd1; operand_b = 32'd1; start = 1'b1;
      @(posedge ACLK); #1;
      start = 1'b0; irq_clr = 1'b1;
      @(posedge ACLK); #1;
      irq_clr = 1'b0;
      chk("irq set_wins", {62'd0, done, irq}, 64'd3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
